shbus_deserializer: RTL and testbench

Sequential successor to the combinational bus-to-packed sharing remap. It accepts a masked value as `nbeats` consecutive beats of `count` shared bits each, in bus representation (bit-major), over a valid/ready handshake. It buffers them and presents the full `count*nbeats`-bit sharing in packed-shares representation (share-major) on a second valid/ready port. It sits between narrow masked-data ingress (e.g. key/plaintext loading) and wide masked cores.

---
 rtl/shbus_deserializer_pkg.sv | 9 +
 rtl/shbus_deserializer_shbus2shares.sv | 19 +
 rtl/shbus_deserializer.sv | 92 +++++++++
 tb/tb_shbus_deserializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shbus_deserializer_pkg.sv
// Shared helpers for the masked-bus deserializer.
//   cnt_width(n) : width of a counter that must hold 0..n inclusive.
package shbus_deserializer_pkg;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shbus_deserializer_shbus2shares.sv
// Bus-to-packed sharing remap (pure wiring).
//   shbus  : bus representation, bit d*i+j = share j of bit i
//   shares : packed representation, bit count*j+i = share j of bit i
module shbus2shares #(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 8
) (
    input  logic [d*count-1:0] shbus,
    output logic [d*count-1:0] shares
);

    // Each output wire is driven by exactly one input wire; shares never mix.
    for (genvar j = 0; j < d; j++) begin : g_share
        for (genvar i = 0; i < count; i++) begin : g_bit
            assign shares[count*j+i] = shbus[d*i+j];
        end
    end

endmodule

// File: rtl/shbus_deserializer.sv
// Masked-data deserializer: collects nbeats bus-representation beats of
// count shared bits and presents the whole sharing in packed representation.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake, in_shbus = beat (d*count bits)
//   out_valid/out_ready : output sharing handshake, out_shares = d*count*nbeats bits
// Build option SHBUS_DESER_CLEAR_EN: zero unused buffer slots on output fire and
// blank out_shares while out_valid is low.
module shbus_deserializer
    import shbus_deserializer_pkg::*;
#(
    parameter int unsigned d      = 2,
    parameter int unsigned count  = 8,
    parameter int unsigned nbeats = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [d*count-1:0]          in_shbus,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [d*count*nbeats-1:0]   out_shares
);

    localparam int unsigned W_BEAT = d * count;
    localparam int unsigned W_OUT  = d * count * nbeats;
    localparam int unsigned CNT_W  = cnt_width(nbeats);

    logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
    logic [W_OUT-1:0] beat_buf_q, beat_buf_d;
    logic [W_OUT-1:0] remap;
    logic             out_valid_q, out_valid_d;
    logic             in_fire, out_fire;

    // Full is tracked by its own flop so out_valid is a clean register output.
    assign out_valid = out_valid_q;
    assign in_ready  = !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    // Next-state: output fire restarts at slot 0, so a concurrent beat lands there.
    always_comb begin
        cnt_d      = cnt_q;
        beat_buf_d = beat_buf_q;
        wr_idx     = cnt_q;
        if (out_fire) begin
            cnt_d  = '0;
            wr_idx = '0;
`ifdef SHBUS_DESER_CLEAR_EN
            beat_buf_d = '0;
`endif
        end
        if (in_fire) begin
            for (int unsigned k = 0; k < nbeats; k++) begin
                if (wr_idx == CNT_W'(k)) begin
                    beat_buf_d[k*W_BEAT +: W_BEAT] = in_shbus;
                end
            end
            cnt_d = cnt_d + CNT_W'(1);
        end
        out_valid_d = (cnt_d == CNT_W'(nbeats));
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            beat_buf_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            beat_buf_q  <= beat_buf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // The concatenated slots form one wide bus-representation sharing.
    shbus2shares #(
        .d     (d),
        .count (count * nbeats)
    ) u_remap (
        .shbus  (beat_buf_q),
        .shares (remap)
    );

`ifdef SHBUS_DESER_CLEAR_EN
    assign out_shares = out_valid_q ? remap : '0;
`else
    assign out_shares = remap;
`endif

endmodule

// File: tb/tb_shbus_deserializer.sv
// Self-checking bench for shbus_deserializer: directed scenarios on a
// d=2,count=2,nbeats=2 instance plus randomized traffic on d=3,count=8,
// nbeats=5 and d=1,count=1,nbeats=1 instances, checked against a beat-queue model.
module tb_shbus_deserializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Instance A: d=2, count=2, nbeats=2
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [3:0]  a_in_shbus = '0;
    logic [7:0]  a_out_shares;
    // Instance B: d=3, count=8, nbeats=5
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [23:0] b_in_shbus = '0;
    logic [119:0] b_out_shares;
    // Instance C: d=1, count=1, nbeats=1
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [0:0]  c_in_shbus = '0;
    logic [0:0]  c_out_shares;

    shbus_deserializer #(.d(2), .count(2), .nbeats(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_shbus(a_in_shbus),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_shares(a_out_shares)
    );
    shbus_deserializer #(.d(3), .count(8), .nbeats(5)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_shbus(b_in_shbus),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_shares(b_out_shares)
    );
    shbus_deserializer #(.d(1), .count(1), .nbeats(1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_shbus(c_in_shbus),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_shares(c_out_shares)
    );

    // Model: beats held for the sharing currently being assembled, in arrival order.
    logic [31:0] mb [16];

    // Expected packed sharing from the index rule: out[cc*nb*j + k*cc + b] = beat_k[dd*b + j].
    function automatic logic [127:0] exp_out(input int dd, input int cc, input int nb);
        logic [127:0] r;
        logic [31:0]  beat;
        r = '0;
        for (int k = 0; k < nb; k++) begin
            beat = mb[k];
            for (int j = 0; j < dd; j++)
                for (int b = 0; b < cc; b++)
                    r[cc*nb*j + k*cc + b] = beat[dd*b + j];
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [127:0] z;
        z = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL reset_a_out_valid got %b want 0", a_out_valid); else pass_cnt++;
        total_cnt++;
        if (a_in_ready !== 1'b1) $display("FAIL reset_a_in_ready got %b want 1", a_in_ready); else pass_cnt++;
        total_cnt++;
        if (a_out_shares !== z[7:0]) $display("FAIL reset_a_out_shares got %h want 0", a_out_shares); else pass_cnt++;
        total_cnt++;
        if (b_out_valid !== 1'b0 || b_out_shares !== z[119:0])
            $display("FAIL reset_b got valid=%b shares=%h want 0/0", b_out_valid, b_out_shares); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    // Beats 1001 then 0110 -> 8'h69 one edge after the second beat.
    task automatic test_basic();
        @(negedge clk);
        a_in_valid = 1'b1; a_in_shbus = 4'b1001; a_out_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL basic_partial_valid got %b want 0", a_out_valid); else pass_cnt++;
        a_in_shbus = 4'b0110;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        total_cnt++;
        if (a_out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", a_out_valid); else pass_cnt++;
        total_cnt++;
        if (a_out_shares !== 8'h69) $display("FAIL basic_shares got %h want 69", a_out_shares); else pass_cnt++;
    endtask

    // Full with out_ready low: no input accepted, output frozen for 10 cycles.
    task automatic test_backpressure();
        logic [7:0] idle_exp;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_shbus = 4'hF; a_out_ready = 1'b0;
            #1;
            total_cnt++;
            if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", t, a_in_ready); else pass_cnt++;
            total_cnt++;
            if (a_out_valid !== 1'b1 || a_out_shares !== 8'h69)
                $display("FAIL bp_hold cyc %0d got valid=%b shares=%h want 1/69", t, a_out_valid, a_out_shares); else pass_cnt++;
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        #1;
`ifdef SHBUS_DESER_CLEAR_EN
        idle_exp = 8'h00;
`else
        idle_exp = 8'h69;
`endif
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL bp_consumed_valid got %b want 0", a_out_valid); else pass_cnt++;
        total_cnt++;
        if (a_out_shares !== idle_exp) $display("FAIL idle_shares got %h want %h", a_out_shares, idle_exp); else pass_cnt++;
    endtask

    // Continuous valid/ready: a sharing every second cycle, nothing lost.
    task automatic test_streaming();
        logic [3:0]   sb [8];
        logic [127:0] e;
        logic         exp_v;
        int           n_out;
        n_out = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            a_in_valid  = (t < 8);
            if (t < 8) begin
                sb[t] = 4'($urandom);
                a_in_shbus = sb[t];
            end
            #1;
            exp_v = (t >= 2) && (t % 2 == 0);
            total_cnt++;
            if (a_out_valid !== exp_v) $display("FAIL stream_valid cyc %0d got %b want %b", t, a_out_valid, exp_v); else pass_cnt++;
            total_cnt++;
            if (a_in_ready !== 1'b1) $display("FAIL stream_in_ready cyc %0d got %b want 1", t, a_in_ready); else pass_cnt++;
            if (exp_v) begin
                mb[0] = 32'(sb[t-2]);
                mb[1] = 32'(sb[t-1]);
                e = exp_out(2, 2, 2);
                n_out++;
                total_cnt++;
                if (a_out_shares !== e[7:0]) $display("FAIL stream_data cyc %0d got %h want %h", t, a_out_shares, e[7:0]); else pass_cnt++;
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        total_cnt++;
        if (n_out != 4) $display("FAIL stream_count got %0d want 4", n_out); else pass_cnt++;
    endtask

    // Reset discards a partial sharing and asynchronously drops a full one.
    task automatic test_reset_mid();
        logic [127:0] e;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_shbus = 4'hA; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_in_valid = 1'b1; a_in_shbus = 4'h3;
        @(negedge clk);
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL rstmid_partial_valid got %b want 0", a_out_valid); else pass_cnt++;
        a_in_shbus = 4'h5;
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        mb[0] = 32'h3; mb[1] = 32'h5;
        e = exp_out(2, 2, 2);
        total_cnt++;
        if (a_out_valid !== 1'b1 || a_out_shares !== e[7:0])
            $display("FAIL rstmid_sharing got valid=%b shares=%h want 1/%h", a_out_valid, a_out_shares, e[7:0]); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (a_out_valid !== 1'b0 || a_out_shares !== 8'h00)
            $display("FAIL rst_async_drop got valid=%b shares=%h want 0/00", a_out_valid, a_out_shares); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random stalls on d=3,count=8,nbeats=5 against the beat-queue model.
    task automatic test_random_b();
        logic [127:0] e;
        logic         full, rdy;
        int           n_held, n_out;
        n_held = 0; n_out = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_shbus  = 24'($urandom);
            b_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            full = (n_held == 5);
            rdy  = !full || b_out_ready;
            total_cnt++;
            if (b_out_valid !== full) $display("FAIL rand_b_valid cyc %0d got %b want %b", t, b_out_valid, full); else pass_cnt++;
            total_cnt++;
            if (b_in_ready !== rdy) $display("FAIL rand_b_in_ready cyc %0d got %b want %b", t, b_in_ready, rdy); else pass_cnt++;
            if (full) begin
                e = exp_out(3, 8, 5);
                total_cnt++;
                if (b_out_shares !== e[119:0]) $display("FAIL rand_b_data cyc %0d got %h want %h", t, b_out_shares, e[119:0]); else pass_cnt++;
                if (b_out_ready) begin n_held = 0; n_out++; end
            end
            if (b_in_valid && rdy) begin
                mb[n_held] = 32'(b_in_shbus);
                n_held++;
            end
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        total_cnt++;
        if (n_out < 10) $display("FAIL rand_b_throughput got %0d want >=10", n_out); else pass_cnt++;
    endtask

    // Random stalls on the degenerate d=1,count=1,nbeats=1 register slice.
    task automatic test_random_c();
        logic [127:0] e;
        logic         full, rdy;
        int           n_held;
        n_held = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            c_in_valid  = ($urandom_range(0, 2) != 0);
            c_in_shbus  = 1'($urandom);
            c_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            full = (n_held == 1);
            rdy  = !full || c_out_ready;
            total_cnt++;
            if (c_out_valid !== full) $display("FAIL rand_c_valid cyc %0d got %b want %b", t, c_out_valid, full); else pass_cnt++;
            total_cnt++;
            if (c_in_ready !== rdy) $display("FAIL rand_c_in_ready cyc %0d got %b want %b", t, c_in_ready, rdy); else pass_cnt++;
            if (full) begin
                e = exp_out(1, 1, 1);
                total_cnt++;
                if (c_out_shares !== e[0:0]) $display("FAIL rand_c_data cyc %0d got %b want %b", t, c_out_shares, e[0]); else pass_cnt++;
                if (c_out_ready) n_held = 0;
            end
            if (c_in_valid && rdy) begin
                mb[n_held] = 32'(c_in_shbus);
                n_held++;
            end
        end
        c_in_valid = 1'b0; c_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_random_b();
        test_random_c();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
